// File: rtl/codigo_display.sv
// Receive side of the dispenser code bus: synchronise and debounce the 4-bit code,
// keep the last four accepted codes and scan them onto a 4-digit active-low 7-segment display.
module codigo_display #(
    parameter int SCAN_DIV  = 16,
    parameter int STABLE    = 4,
    parameter int BLINK_DIV = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] code_in,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       nuevo,
    output logic [3:0] codigo
);

    localparam logic [3:0] CODE_IDLE = 4'hA;
    localparam logic [3:0] CODE_OUT  = 4'hB;
    localparam int CNT_W   = (STABLE > 1)    ? $clog2(STABLE)    : 1;
    localparam int SCAN_W  = (SCAN_DIV > 1)  ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(STABLE - 1);
    localparam logic [SCAN_W-1:0]  SCAN_MAX  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV - 1);

    // Active-low segment pattern {g,f,e,d,c,b,a} for one digit.
    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h7F;
            4'hB:    s = 7'h03;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    logic [3:0]         sync_p0, sync_p1;
    logic [3:0]         cand;
    logic [CNT_W-1:0]   cnt;
    logic [3:0][3:0]    digits;
    logic               accept;
    logic               blink_on, phase;
    logic [BLINK_W-1:0] blink_cnt;
    logic [SCAN_W-1:0]  scan_cnt;
    logic [1:0]         idx;
    logic               blank_d0;

    // Stage boundary: two-flop synchroniser on the asynchronous code bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= CODE_IDLE;
            sync_p1 <= CODE_IDLE;
        end else begin
            sync_p0 <= code_in;
            sync_p1 <= sync_p0;
        end
    end

    // Stage boundary: debounce; cnt saturates so a held code is accepted only once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand <= CODE_IDLE;
            cnt  <= '0;
        end else if (sync_p1 != cand) begin
            cand <= sync_p1;
            cnt  <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt  <= cnt + 1'b1;
        end
    end

    assign accept = (cnt == CNT_MAX) && (cand != codigo);
    assign nuevo  = accept;

    // Stage boundary: accepted-code history, d0 is the newest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            codigo <= CODE_IDLE;
            digits <= {4{CODE_IDLE}};
        end else if (accept) begin
            codigo <= cand;
            digits <= {digits[2:0], cand};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_on  <= 1'b0;
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (accept) begin
            blink_on  <= (cand == CODE_OUT);
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (blink_on) begin
            if (blink_cnt == BLINK_MAX) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            idx      <= 2'd0;
        end else if (scan_cnt == SCAN_MAX) begin
            scan_cnt <= '0;
            idx      <= idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    assign an       = ~(4'b0001 << idx);
    assign blank_d0 = blink_on && phase && (idx == 2'd0);

    // Stage boundary: registered segment drive, one cycle behind the digit enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= 7'h7F;
        end else begin
            seg <= blank_d0 ? 7'h7F : decode(digits[idx]);
        end
    end

endmodule

// File: tb/tb_codigo_display.sv
// Bench for codigo_display: random and directed code sequences against a sample-history
// reference model; accept pulses go through a scoreboard queue, display pins are checked each cycle.
module tb_codigo_display;

    localparam int SCAN_DIV  = 16;
    localparam int STABLE    = 4;
    localparam int BLINK_DIV = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] code_in = 4'hA;
    logic [6:0] seg;
    logic [3:0] an;
    logic       nuevo;
    logic [3:0] codigo;

    codigo_display #(.SCAN_DIV(SCAN_DIV), .STABLE(STABLE), .BLINK_DIV(BLINK_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .code_in(code_in),
        .seg(seg), .an(an), .nuevo(nuevo), .codigo(codigo)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         cyc;
        logic [3:0] code;
    } ev_t;
    ev_t sb[$];

    // Segment letters lit per glyph, turned into active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1000000; // abcdef
            4'h1: return 7'b1111001; // bc
            4'h2: return 7'b0100100; // abdeg
            4'h3: return 7'b0110000; // abcdg
            4'h4: return 7'b0011001; // bcfg
            4'h5: return 7'b0010010; // acdfg
            4'h6: return 7'b0000010; // acdefg
            4'h7: return 7'b1111000; // abc
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000; // abcdfg
            4'hA: return 7'b1111111; // blank
            4'hB: return 7'b0000011; // cdefg
            default: return 7'b0111111; // g only
        endcase
    endfunction

    // Reference model: hist holds code_in as sampled at every edge since reset,
    // preceded by three idle entries standing for the reset synchroniser/candidate.
    logic [3:0] hist[$];
    logic [3:0] m_cod;
    logic [3:0] m_dig[4];
    bit         m_blink;
    int         m_bstart;
    bit         m_pend;
    logic [3:0] m_pend_code;
    int         cyc;
    logic [6:0] e_seg;
    logic [3:0] e_an;
    int         m_k, m_pidx;
    logic [3:0] m_v;
    bit         m_run, m_blank;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist.delete();
            for (int i = 0; i < 3; i++) hist.push_back(4'hA);
            m_cod = 4'hA;
            for (int i = 0; i < 4; i++) m_dig[i] = 4'hA;
            m_blink = 0;
            m_bstart = 0;
            m_pend = 0;
            m_pend_code = 4'hA;
            cyc = 0;
            e_seg = 7'h7F;
            e_an = 4'b1110;
            sb.delete();
        end else begin
            m_k = cyc + 1;
            m_pidx = ((m_k - 1) / SCAN_DIV) % 4;
            m_blank = m_blink && (m_pidx == 0) && ((((m_k - 1 - m_bstart) / BLINK_DIV) % 2) == 1);
            e_seg = m_blank ? 7'h7F : glyph(m_dig[m_pidx]);
            if (m_pend) begin
                m_cod = m_pend_code;
                m_dig[3] = m_dig[2];
                m_dig[2] = m_dig[1];
                m_dig[1] = m_dig[0];
                m_dig[0] = m_pend_code;
                m_blink = (m_pend_code == 4'hB);
                m_bstart = m_k;
            end
            e_an = ~(4'b0001 << ((m_k / SCAN_DIV) % 4));
            hist.push_back(code_in);
            m_v = hist[m_k];
            m_run = (m_k >= STABLE - 1);
            for (int j = 1; j < STABLE; j++)
                if (m_run && hist[m_k - j] != m_v) m_run = 0;
            m_pend = m_run && (m_v != m_cod);
            if (m_pend) begin
                m_pend_code = m_v;
                sb.push_back('{m_k, m_v});
            end
            cyc = m_k;
        end
    end

    // Monitor: compares display pins every cycle and pops the scoreboard on accept pulses.
    ev_t ev;
    bit  exp_n;
    always @(negedge clk) begin
        total++;
        if (an !== e_an) begin
            bad++;
            $display("FAIL an cyc=%0d got=%b want=%b", cyc, an, e_an);
        end
        total++;
        if (seg !== e_seg) begin
            bad++;
            $display("FAIL seg cyc=%0d got=%h want=%h", cyc, seg, e_seg);
        end
        total++;
        if (codigo !== m_cod) begin
            bad++;
            $display("FAIL codigo cyc=%0d got=%h want=%h", cyc, codigo, m_cod);
        end
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            ev = sb.pop_front();
            total++;
            bad++;
            $display("FAIL nuevo_missed cyc=%0d got=none want=pulse at cyc %0d", cyc, ev.cyc);
        end
        exp_n = 0;
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            ev = sb.pop_front();
            exp_n = 1;
        end
        total++;
        if (nuevo !== exp_n) begin
            bad++;
            $display("FAIL nuevo cyc=%0d got=%b want=%b", cyc, nuevo, exp_n);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic hold(input logic [3:0] c, input int n);
        @(negedge clk);
        code_in = c;
        repeat (n - 1) @(negedge clk);
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        code_in = 4'hA;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_an", an, 4'b1110);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_codigo", codigo, 4'hA);
        chk("rst_nuevo", nuevo, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // A -> 3: pulse exactly six edges after the change
        code_in = 4'h3;
        repeat (5) @(posedge clk);
        #1 chk("lat_before", nuevo, 1'b0);
        @(posedge clk);
        #1 chk("lat_pulse", nuevo, 1'b1);
        @(posedge clk);
        #1 chk("lat_after", nuevo, 1'b0);
        chk("codigo_3", codigo, 4'h3);
        repeat (10) @(negedge clk);

        // Short glitch to 7 is ignored
        hold(4'h7, 2);
        hold(4'h3, 20);
        chk("glitch_codigo", codigo, 4'h3);

        // Fill all four digits and watch a full scan round
        hold(4'h1, 10);
        hold(4'h2, 10);
        hold(4'h3, 10);
        hold(4'h4, 10);
        repeat (80) @(negedge clk);
        chk("fill_codigo", codigo, 4'h4);

        // Product-out blink, then a steady 5
        hold(4'hB, 320);
        hold(4'h5, 150);
        chk("after_blink_codigo", codigo, 4'h5);

        // Reset in the middle of blinking and of a debounce
        hold(4'hB, 100);
        @(negedge clk);
        code_in = 4'h7;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_an", an, 4'b1110);
        chk("mid_rst_seg", seg, 7'h7F);
        chk("mid_rst_codigo", codigo, 4'hA);
        chk("mid_rst_nuevo", nuevo, 1'b0);
        code_in = 4'hA;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("post_rst_codigo", codigo, 4'hA);

        // Random traffic with occasional long product-out holds and async resets
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 11) == 0) begin
                hold(4'hB, $urandom_range(100, 200));
            end else begin
                hold(4'($urandom_range(0, 15)), $urandom_range(1, 12));
            end
            if ($urandom_range(0, 59) == 0) begin
                @(posedge clk);
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        repeat (20) @(negedge clk);
        chk("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        bad++;
        $display("FAIL watchdog got=timeout want=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
